// File: rtl/bridge_sg2_responder.sv
// ============================================================================
// Module   : bridge_sg2_responder
// Brief    : Slave-group-2 responder for the bit-serial system bus. Receives
//            request frames, issues a local valid/ready transfer, and acks /
//            serialises read data back. Optional macro: BRIDGE_SG2_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bridge_sg2_responder #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              b_rw,
  input  logic              b_bus_out,
  output logic              b_ack,
  output logic              b_sbst,
  output logic              b_bus_in,
  output logic              s_valid,
  output logic              s_write,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  input  logic              s_ready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic              s_rvalid
`ifdef BRIDGE_SG2_PARITY_EN
  ,
  output logic [7:0]        par_err_cnt
`endif
);

  localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W = $clog2(MAX_W + 1);
`ifdef BRIDGE_SG2_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  // The parity slot sits one position past the last field bit.
  localparam logic [CNT_W-1:0] ADDR_PAR  = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] DATA_PAR  = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] TX_LAST   = PAR_EN ? CNT_W'(DATA_W) : CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RX_ADDR  = 3'd1,
    RX_DATA  = 3'd2,
    SLV_REQ  = 3'd3,
    SLV_WAIT = 3'd4,
    TX_START = 3'd5,
    TX_DATA  = 3'd6,
    ACK      = 3'd7
  } state_t;

  state_t            state_q,   state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              write_q,   write_d;
  logic [ADDR_W-1:0] addr_q,    addr_d;
  logic [DATA_W-1:0] data_q,    data_d;
  logic [DATA_W-1:0] rdata_q,   rdata_d;
  logic              par_q,     par_d;
  logic              tx_par_q,  tx_par_d;
`ifdef BRIDGE_SG2_PARITY_EN
  logic [7:0]        par_err_cnt_q, par_err_cnt_d;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      rdata_q   <= '0;
      par_q     <= 1'b0;
      tx_par_q  <= 1'b0;
`ifdef BRIDGE_SG2_PARITY_EN
      par_err_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      rdata_q   <= rdata_d;
      par_q     <= par_d;
      tx_par_q  <= tx_par_d;
`ifdef BRIDGE_SG2_PARITY_EN
      par_err_cnt_q <= par_err_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    write_d   = write_q;
    addr_d    = addr_q;
    data_d    = data_q;
    rdata_d   = rdata_q;
    par_d     = par_q;
    tx_par_d  = tx_par_q;
`ifdef BRIDGE_SG2_PARITY_EN
    par_err_cnt_d = par_err_cnt_q;
`endif
    b_ack     = 1'b0;
    b_bus_in  = 1'b0;
    s_valid   = 1'b0;

    case (state_q)
      IDLE: begin
        if (b_bus_out) begin
          write_d   = b_rw;
          par_d     = b_rw;
          bit_cnt_d = '0;
          data_d    = '0;
          state_d   = RX_ADDR;
        end
      end

      RX_ADDR: begin
        if (PAR_EN && !write_q && (bit_cnt_q == ADDR_PAR)) begin
          bit_cnt_d = '0;
          if (par_q ^ b_bus_out) begin
            state_d = IDLE;
`ifdef BRIDGE_SG2_PARITY_EN
            if (par_err_cnt_q != 8'hFF) par_err_cnt_d = par_err_cnt_q + 8'd1;
`endif
          end else begin
            state_d = SLV_REQ;
          end
        end else begin
          // Fields arrive LSB first, so shift in from the top.
          addr_d = {b_bus_out, addr_q[ADDR_W-1:1]};
          par_d  = par_q ^ b_bus_out;
          if (bit_cnt_q == ADDR_LAST) begin
            if (write_q) begin
              bit_cnt_d = '0;
              state_d   = RX_DATA;
            end else if (PAR_EN) begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end else begin
              bit_cnt_d = '0;
              state_d   = SLV_REQ;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end

      RX_DATA: begin
        if (PAR_EN && (bit_cnt_q == DATA_PAR)) begin
          bit_cnt_d = '0;
          if (par_q ^ b_bus_out) begin
            state_d = IDLE;
`ifdef BRIDGE_SG2_PARITY_EN
            if (par_err_cnt_q != 8'hFF) par_err_cnt_d = par_err_cnt_q + 8'd1;
`endif
          end else begin
            state_d = SLV_REQ;
          end
        end else begin
          data_d = {b_bus_out, data_q[DATA_W-1:1]};
          par_d  = par_q ^ b_bus_out;
          if (bit_cnt_q == DATA_LAST) begin
            if (PAR_EN) begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end else begin
              bit_cnt_d = '0;
              state_d   = SLV_REQ;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end

      SLV_REQ: begin
        s_valid = 1'b1;
        if (s_ready) state_d = write_q ? ACK : SLV_WAIT;
      end

      SLV_WAIT: begin
        if (s_rvalid) begin
          rdata_d  = s_rdata;
          tx_par_d = ^s_rdata;
          state_d  = TX_START;
        end
      end

      TX_START: begin
        b_ack     = 1'b1;
        b_bus_in  = 1'b1;
        bit_cnt_d = '0;
        state_d   = TX_DATA;
      end

      TX_DATA: begin
        b_bus_in = (PAR_EN && (bit_cnt_q == DATA_PAR)) ? tx_par_q : rdata_q[0];
        rdata_d  = rdata_q >> 1;
        if (bit_cnt_q == TX_LAST) begin
          bit_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end

      ACK: begin
        b_ack   = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign b_sbst  = (state_q != IDLE);
  assign s_write = s_valid & write_q;
  assign s_addr  = s_valid ? addr_q : '0;
  assign s_wdata = s_valid ? data_q : '0;
`ifdef BRIDGE_SG2_PARITY_EN
  assign par_err_cnt = par_err_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bridge_sg2_responder.sv
// ============================================================================
// Module   : tb_bridge_sg2_responder
// Brief    : Directed vector bench for bridge_sg2_responder (default build).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bridge_sg2_responder;

  localparam int AW = 12;
  localparam int DW = 8;

  logic          clk;
  logic          rstn;
  logic          b_rw;
  logic          b_bus_out;
  logic          b_ack;
  logic          b_sbst;
  logic          b_bus_in;
  logic          s_valid;
  logic          s_write;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic          s_ready;
  logic [DW-1:0] s_rdata;
  logic          s_rvalid;

  int checks;
  int failures;

  bridge_sg2_responder #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .b_rw      (b_rw),
    .b_bus_out (b_bus_out),
    .b_ack     (b_ack),
    .b_sbst    (b_sbst),
    .b_bus_in  (b_bus_in),
    .s_valid   (s_valid),
    .s_write   (s_write),
    .s_addr    (s_addr),
    .s_wdata   (s_wdata),
    .s_ready   (s_ready),
    .s_rdata   (s_rdata),
    .s_rvalid  (s_rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int            ready_from;  // first frame cycle with s_ready high
    int            rv_lat;      // s_rvalid cycles after the handshake
    logic          inj;         // extra start bit during SLV_WAIT
    int            exp_valid;   // first s_valid cycle
    int            exp_ack;     // b_ack cycle
    int            exp_last;    // last busy cycle
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {7'd0, b_ack, b_sbst, b_bus_in, s_valid, s_write, s_addr, s_wdata};
  endfunction

  task automatic run_frame(input vec_t v);
    int hs = -1, first_valid = -1, n_hs = 0, n_ack = 0, ack_t = -1;
    int sbst_err = 0, zero_err = 0, hold_err = 0, busin_err = 0;
    logic [AW-1:0] hs_addr = '0;
    logic [DW-1:0] hs_wdata = '0;
    logic [DW-1:0] rx = '0;
    logic          hs_write = 1'b0;
    logic          rx_start = 1'b0;
    logic          in_valid = 1'b0;
    logic [AW+DW:0] held = '0;
    for (int t = 0; t <= v.exp_last; t++) begin
      @(posedge clk);
      #1;
      b_rw      = (t == 0) ? v.rw : ~v.rw;
      b_bus_out = 1'b0;
      if (t == 0) b_bus_out = 1'b1;
      else if (t <= AW) b_bus_out = v.addr[t-1];
      else if (v.rw && t <= AW + DW) b_bus_out = v.wdata[t-1-AW];
      if (v.inj && hs >= 0 && t == hs + 1) b_bus_out = 1'b1;
      s_ready  = (t >= v.ready_from);
      s_rvalid = (hs >= 0 && t == hs + v.rv_lat);
      s_rdata  = v.rdata;
      @(negedge clk);
      if (s_valid) begin
        if (first_valid < 0) first_valid = t;
        if (in_valid && held != {s_write, s_addr, s_wdata}) hold_err++;
        held     = {s_write, s_addr, s_wdata};
        in_valid = 1'b1;
        if (s_ready) begin
          n_hs++;
          hs       = t;
          hs_addr  = s_addr;
          hs_wdata = s_wdata;
          hs_write = s_write;
        end
      end else begin
        in_valid = 1'b0;
        if (s_write || s_addr != '0 || s_wdata != '0) zero_err++;
      end
      if (b_sbst != (t >= 1)) sbst_err++;
      if (b_ack) begin
        n_ack++;
        if (ack_t < 0) ack_t = t;
      end
      if (ack_t >= 0 && t == ack_t) rx_start = b_bus_in;
      else if (ack_t >= 0 && t > ack_t && t <= ack_t + DW) rx[t-ack_t-1] = b_bus_in;
      else if (b_bus_in) busin_err++;
    end
    chk("valid_cycle", first_valid, v.exp_valid);
    chk("handshakes", n_hs, 1);
    chk("s_addr", int'(hs_addr), int'(v.addr));
    chk("s_write", int'(hs_write), int'(v.rw));
    if (v.rw) chk("s_wdata", int'(hs_wdata), int'(v.wdata));
    chk("req_hold", hold_err, 0);
    chk("s_zero_when_idle", zero_err, 0);
    chk("ack_count", n_ack, 1);
    chk("ack_cycle", ack_t, v.exp_ack);
    chk("sbst_profile", sbst_err, 0);
    chk("bus_in_quiet", busin_err, 0);
    if (!v.rw) begin
      chk("rx_start_bit", int'(rx_start), 1);
      chk("rx_data", int'(rx), int'(v.rdata));
    end
  endtask

  vec_t vecs[6];
  logic sbst_before;
  logic [AW-1:0] ma;
  logic [DW-1:0] md;

  initial begin
    checks    = 0;
    failures  = 0;
    rstn      = 1'b0;
    b_rw      = 1'b0;
    b_bus_out = 1'b0;
    s_ready   = 1'b0;
    s_rdata   = '0;
    s_rvalid  = 1'b0;

    //          rw    addr      wdata  rdata  rdy rv inj  valid ack last
    vecs[0] = '{1'b1, 12'h0A5, 8'h3C, 8'h00, 0,  0, 1'b0, 21, 22, 22};
    vecs[1] = '{1'b0, 12'h7FF, 8'h00, 8'hA6, 0,  3, 1'b0, 13, 17, 25};
    vecs[2] = '{1'b1, 12'h123, 8'h5A, 8'h00, 26, 0, 1'b0, 21, 27, 27};
    vecs[3] = '{1'b0, 12'h000, 8'h00, 8'h81, 0,  3, 1'b1, 13, 17, 25};
    vecs[4] = '{1'b0, 12'h800, 8'h00, 8'hFF, 16, 2, 1'b0, 13, 19, 27};
    vecs[5] = '{1'b1, 12'hFFF, 8'h00, 8'h00, 0,  0, 1'b0, 21, 22, 22};

    repeat (3) @(negedge clk);
    chk("reset_outputs", int'(outs()), 0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_outputs", int'(outs()), 0);

    // Reset in the middle of the data field of a write frame.
    ma = 12'h0A5;
    md = 8'h3C;
    for (int t = 0; t <= 15; t++) begin
      @(posedge clk);
      #1;
      b_rw      = 1'b1;
      b_bus_out = (t == 0) ? 1'b1 : (t <= AW) ? ma[t-1] : md[t-1-AW];
    end
    #2;
    sbst_before = b_sbst;
    rstn = 1'b0;
    #1;
    chk("busy_before_reset", int'(sbst_before), 1);
    chk("outputs_in_reset", int'(outs()), 0);
    @(negedge clk);
    b_bus_out = 1'b0;
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_after_reset", int'(outs()), 0);

    for (int i = 0; i < 6; i++) run_frame(vecs[i]);

    @(posedge clk);
    #1;
    b_bus_out = 1'b0;
    s_rvalid  = 1'b0;
    repeat (3) @(negedge clk);
    chk("final_idle", int'(outs()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bridge_sg2_responder.md
Name: bridge_sg2_responder

Overview:
- Slave-group-2 end of the bit-serial system bus; counterpart of the master-side bridge that drives B_RW/B_BUS_OUT and samples B_ACK/B_SBST/B_BUS_IN.
- Deserialises request frames from the line, issues one transfer on a local valid/ready slave port, then acknowledges and, for reads, serialises read data back.
- One instance per slave group 2 target.

Parameters:
- ADDR_W, 12, address bits per frame
- DATA_W, 8, data bits per frame and local data width

Ports:
- clk  in  1  system clock, all logic on posedge
- rstn  in  1  asynchronous active-low reset
- b_rw  in  1  frame direction, sampled with start bit (1=write, 0=read)
- b_bus_out  in  1  serial line from initiator; idles 0
- b_ack  out  1  one-cycle completion pulse to initiator
- b_sbst  out  1  responder busy/status, high while a frame is in progress
- b_bus_in  out  1  serial read-data line to initiator; idles 0
- s_valid  out  1  local request valid
- s_write  out  1  local request is write
- s_addr  out  ADDR_W  local address
- s_wdata  out  DATA_W  local write data
- s_ready  in  1  local slave accepts request
- s_rdata  in  DATA_W  local read data
- s_rvalid  in  1  s_rdata valid

Behaviour:
- Clock/reset: single clock clk; rstn asynchronous active-low. Reset (including mid-frame) forces IDLE, clears bit counter and shift registers; all outputs 0.
- Frame format: start bit 1 on b_bus_out, then ADDR_W address bits LSB first, then (writes only) DATA_W data bits LSB first, one bit per cycle.
- States: IDLE, RX_ADDR, RX_DATA, SLV_REQ, SLV_WAIT, TX_START, TX_DATA, ACK.
- IDLE: b_bus_out==1 -> latch b_rw -> RX_ADDR, bit_cnt=0.
- RX_ADDR: shift bit into addr[bit_cnt]. After ADDR_W bits: write -> RX_DATA, read -> SLV_REQ.
- RX_DATA: shift DATA_W bits, then -> SLV_REQ.
- SLV_REQ: s_valid=1 with registered s_write/s_addr/s_wdata held stable. Transfer occurs on s_valid&&s_ready. Then write -> ACK, read -> SLV_WAIT.
- SLV_WAIT: s_rvalid sampled from the cycle after the handshake. When high, capture s_rdata -> TX_START.
- TX_START: b_bus_in=1 and b_ack=1 for one cycle -> TX_DATA.
- TX_DATA: b_bus_in=rdata[bit_cnt] for DATA_W cycles, LSB first -> IDLE.
- ACK (write only): b_ack=1 for one cycle -> IDLE.
- b_sbst: 1 in every state except IDLE; registered, asserted the cycle after the start bit.
- b_bus_out is ignored outside IDLE/RX_ADDR/RX_DATA; start bits while busy are dropped.
- Write latency with s_ready=1: start at cycle 0, s_valid at cycle ADDR_W+DATA_W+1, b_ack at +2.
- s_* outputs are 0 whenever s_valid=0. bit_cnt width is $clog2(max(ADDR_W,DATA_W)+1), with no wrap inside a field.
- Back-to-back: a new start bit is accepted in the first IDLE cycle after ACK/TX_DATA.

Optional Feature:
- Macro BRIDGE_SG2_PARITY_EN.
- Defined:
  - Request frames carry one even-parity bit after the last address/data bit, covering b_rw, address and data.
  - On mismatch: no local request, no b_ack, return to IDLE, and the 8-bit saturating output par_err_cnt increments.
  - Read responses append an even-parity bit over rdata after the last data bit.
- Undefined: no parity bits in either direction; par_err_cnt port absent.

Test Plan:
- Write, defaults, s_ready=1: start, b_rw=1, addr 0x0A5, data 0x3C -> s_valid cycle 21 with s_addr=0x0A5, s_wdata=0x3C, s_write=1; b_ack single pulse cycle 22; b_sbst 1 cycles 1-22.
- Read: addr 0x7FF, s_rvalid 3 cycles after handshake with s_rdata=0xA6 -> b_ack with b_bus_in=1 start, then bits 0,1,1,0,0,1,0,1; then IDLE.
- Backpressure: s_ready low 5 cycles -> s_valid and s_addr/s_wdata held constant; exactly one handshake; single b_ack.
- Start bit asserted during SLV_WAIT -> ignored; no second request; response for the first frame unaffected.
- rstn low mid RX_DATA -> all outputs 0 immediately; the next full frame completes normally.
- BRIDGE_SG2_PARITY_EN: write frame with flipped parity -> no s_valid, no b_ack, par_err_cnt 0->1; correct frame afterwards -> acked.
